// File: rtl/memory_access.sv
// Memory stage of the interpolation ASIP pipeline.
// Performs scalar 32-bit and vector 128-bit (four word beats) loads/stores
// against a 32-bit data-memory port, stalls upstream while an access is in
// flight, and presents registered results to writeback.
module memory_access (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         VecMem,
  input  logic         RegWrite,
  input  logic         VRegWrite,
  input  logic [4:0]   Rd,
  input  logic [31:0]  ALUresult,
  input  logic [31:0]  WriteData,
  input  logic [127:0] VALUresult,
  input  logic [127:0] VWriteData,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ready,
  output logic         out_valid,
  output logic         RegWriteOut,
  output logic         VRegWriteOut,
  output logic [4:0]   RdOut,
  output logic [31:0]  ALUresultOut,
  output logic [127:0] VALUresultOut,
  output logic [31:0]  ReadData,
  output logic [127:0] VReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALAR = 2'd1,
    VECTOR = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [1:0]   beat, beat_next;
  logic         retire_mem;

  // Instruction fields captured at acceptance
  logic         l_read;
  logic         l_we;
  logic         l_vec;
  logic         l_regwrite;
  logic         l_vregwrite;
  logic [4:0]   l_rd;
  logic [31:0]  l_alu;
  logic [31:0]  l_wdata;
  logic [127:0] l_valu;
  logic [127:0] l_vwdata;

  logic accept;
  logic is_mem;
  logic beat_done;

  assign accept    = (state == IDLE) && in_valid;
  assign is_mem    = MemRead | MemWrite;
  assign beat_done = mem_req & mem_ready;

  assign stall     = (state != IDLE);
  assign mem_req   = (state != IDLE);
  assign mem_we    = l_we;
  // Beat stays 0 in SCALAR, so one adder serves both access kinds
  assign mem_addr  = {l_alu[31:2], 2'b00} + {28'd0, beat, 2'b00};
  assign mem_wdata = l_vec ? l_vwdata[{beat, 5'd0} +: 32] : l_wdata;

  // State and beat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Next-state logic: advance on completed beats, retire on the last one
  always_comb begin
    state_next = state;
    beat_next  = beat;
    retire_mem = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_mem) begin
          state_next = VecMem ? VECTOR : SCALAR;
          beat_next  = '0;
        end
      end
      SCALAR: begin
        if (mem_ready) begin
          state_next = IDLE;
          retire_mem = 1'b1;
        end
      end
      VECTOR: begin
        if (mem_ready) begin
          if (beat == 2'd3) begin
            state_next = IDLE;
            beat_next  = '0;
            retire_mem = 1'b1;
          end else begin
            beat_next = beat + 2'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Latch the whole instruction on acceptance; store wins over load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_read      <= 1'b0;
      l_we        <= 1'b0;
      l_vec       <= 1'b0;
      l_regwrite  <= 1'b0;
      l_vregwrite <= 1'b0;
      l_rd        <= '0;
      l_alu       <= '0;
      l_wdata     <= '0;
      l_valu      <= '0;
      l_vwdata    <= '0;
    end else if (accept) begin
      l_read      <= MemRead & ~MemWrite;
      l_we        <= MemWrite;
      l_vec       <= VecMem;
      l_regwrite  <= RegWrite;
      l_vregwrite <= VRegWrite;
      l_rd        <= Rd;
      l_alu       <= ALUresult;
      l_wdata     <= WriteData;
      l_valu      <= VALUresult;
      l_vwdata    <= VWriteData;
    end
  end

  // Writeback outputs: retire pulse, pass-through fields and load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      RegWriteOut   <= 1'b0;
      VRegWriteOut  <= 1'b0;
      RdOut         <= '0;
      ALUresultOut  <= '0;
      VALUresultOut <= '0;
      ReadData      <= '0;
      VReadData     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mem) begin
        out_valid     <= 1'b1;
        RegWriteOut   <= RegWrite;
        VRegWriteOut  <= VRegWrite;
        RdOut         <= Rd;
        ALUresultOut  <= ALUresult;
        VALUresultOut <= VALUresult;
      end else if (retire_mem) begin
        out_valid     <= 1'b1;
        RegWriteOut   <= l_regwrite;
        VRegWriteOut  <= l_vregwrite;
        RdOut         <= l_rd;
        ALUresultOut  <= l_alu;
        VALUresultOut <= l_valu;
      end
      if (beat_done && l_read) begin
        if (state == SCALAR) begin
          ReadData <= mem_rdata;
        end else begin
          VReadData[{beat, 5'd0} +: 32] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the interpolation ASIP pipeline. It sits directly downstream of `execute` and consumes `ALUresult`, `WriteData` and `VALUresult`. It performs scalar 32-bit and vector 128-bit loads and stores against a 32-bit data-memory port, splitting each vector access into four word beats. It stalls the upstream stages while an access is in flight and hands registered results to writeback.

## Interface
- No parameters; all widths are fixed.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: execute presents an instruction.
- `MemRead` in 1: load.
- `MemWrite` in 1: store. Has priority if both `MemRead` and `MemWrite` are set.
- `VecMem` in 1: 1 = 128-bit vector access, 0 = 32-bit scalar access.
- `RegWrite` in 1: pass-through to writeback.
- `VRegWrite` in 1: pass-through to writeback.
- `Rd` in 5: pass-through destination register.
- `ALUresult` in 32: scalar result, also the byte address for memory ops.
- `WriteData` in 32: scalar store data.
- `VALUresult` in 128: vector result, pass-through.
- `VWriteData` in 128: vector store data.
- `stall` out 1: high whenever state ≠ IDLE.
- `mem_req` out 1: data-memory request.
- `mem_we` out 1: write strobe, valid with `mem_req`.
- `mem_addr` out 32: word-aligned byte address.
- `mem_wdata` out 32: store word.
- `mem_rdata` in 32: load word.
- `mem_ready` in 1: memory accepts or completes the current beat.
- `out_valid` out 1: one-cycle pulse per retired instruction.
- `RegWriteOut`, `VRegWriteOut` out 1 each.
- `RdOut` out 5.
- `ALUresultOut` out 32.
- `VALUresultOut` out 128.
- `ReadData` out 32: scalar load result.
- `VReadData` out 128: vector load result.

## Operation
- FSM states: IDLE, SCALAR, VECTOR. There is a 2-bit beat counter.
- Acceptance happens only in IDLE with `in_valid`=1. On acceptance, all inputs are latched.
- Acceptance, non-memory op (`MemRead`=`MemWrite`=0):
  - Pass-through outputs register next edge and `out_valid`=1.
  - State stays IDLE.
- Acceptance, memory op:
  - `VecMem`=0 → SCALAR.
  - `VecMem`=1 → VECTOR, beat=0.
- `mem_req` = (state ≠ IDLE). Memory-port outputs are derived from latched values only, never directly from the `in_*` inputs.
- `mem_addr`:
  - SCALAR: {latched addr[31:2], 2'b00}.
  - VECTOR: that base + 4·beat, wrapping modulo 2^32.
- `mem_we` = latched `MemWrite`.
- `mem_wdata`:
  - SCALAR: `WriteData`.
  - VECTOR: `VWriteData[32·beat+31 : 32·beat]`. Lane 0 goes first.
- A beat completes on an edge with `mem_req`=1 and `mem_ready`=1.
  - For loads, `mem_rdata` is captured into `ReadData` (SCALAR) or into lane beat of `VReadData` (VECTOR) on that edge.
  - `mem_rdata` is ignored at all other times.
- SCALAR: a completed beat → IDLE, with `out_valid`=1 in the following cycle.
- VECTOR: a completed beat with beat<3 → beat+1. A completed beat with beat=3 → IDLE and `out_valid`.
- `ReadData` and `VReadData` hold their previous value on stores and non-memory ops. Vector lanes not yet written keep their old contents until overwritten.
- Pass-through outputs update together with the `out_valid` pulse and hold until the next one.
- `stall`=1 in SCALAR and VECTOR. Upstream must hold its instruction while `stall`=1.

## Timing
- Reset (async, immediate):
  - State IDLE, beat 0.
  - All outputs are 0, including `mem_req`, `stall` and `out_valid`.
  - An in-flight or partial vector access is discarded, with no `out_valid`.
- Acceptance at edge T:
  - Non-memory op: `out_valid` in cycle T+1.
  - Memory op: `mem_req` is high from T+1.
- Scalar memory op:
  - With `mem_ready` tied high, `out_valid` is in cycle T+2.
  - Each wait cycle adds 1.
- Vector memory op:
  - Minimum `out_valid` is in cycle T+5.
  - Waits add per beat.
- When state returns to IDLE, a new instruction can be accepted in the same cycle that `out_valid` is high. Throughput for back-to-back non-memory ops is 1 per cycle.
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1 and `mem_ready`=0.

## Test plan
- Reset mid-operation, then release:
  - Stimulus: assert `rst` in any state.
  - Response: every output is 0 immediately; `out_valid` stays 0 after release until an instruction is accepted.
- Non-memory op:
  - Stimulus: `ALUresult`=1234, `Rd`=5, `RegWrite`=1, `in_valid`=1.
  - Response: next cycle `out_valid`=1, `ALUresultOut`=1234, `RdOut`=5, `stall`=0.
  - Also: back-to-back ops retire every cycle.
- Scalar load:
  - Stimulus: `ALUresult`=0x103, `mem_ready` low for 2 cycles, `mem_rdata`=0xDEADBEEF.
  - Response: `mem_addr`=0x100; `stall`=1 for 3 cycles; `ReadData`=0xDEADBEEF with `out_valid` one cycle after `mem_ready`.
- Vector store:
  - Stimulus: base 0x200, `VWriteData`=0x44444444_33333333_22222222_11111111, `mem_ready`=1.
  - Response: beats at 0x200/0x204/0x208/0x20C carrying 0x11111111, 0x22222222, 0x33333333, 0x44444444; `mem_we`=1; `out_valid` at T+5.
- Vector load with `mem_ready` toggling:
  - Stimulus: memory returns 0xA0..0xA3 per beat.
  - Response: `VReadData`=0x000000A3_000000A2_000000A1_000000A0; address is held during wait cycles.
- Reset mid vector load:
  - Stimulus: assert `rst` after beat 2.
  - Response: `mem_req`=0 immediately and no `out_valid`.
  - Then a scalar store to 0xFFFFFFFC completes with `mem_addr`=0xFFFFFFFC.
